i2c_reg_target: RTL



---
 rtl/i2c_reg_target.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_target.sv
// I2C target emulating a 256x8 register bank at a fixed 7-bit address (ADV7513 stand-in).
// Latency: wr_stb and SDA drive appear FILT_LEN+3 iCLK cycles after the raw SCL edge.
// Backpressure: none; never stretches SCL, commits every acked write byte immediately.
//
// Ports: iCLK/iRST_N (sync, active-low reset), I2C_SCL in, I2C_SDA open-drain inout,
//        wr_stb/wr_addr/wr_data write-event strobe, busy (addressed START until STOP).
// Optional macro I2C_REG_TARGET_HOST_PORT_EN adds host_addr/host_we/host_wdata/host_rdata,
// a local read/write port into the bank (1-cycle registered read, I2C write wins on collision).
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         FILT_LEN = 3
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
`ifdef I2C_REG_TARGET_HOST_PORT_EN
    ,
    input  logic [7:0] host_addr,
    input  logic       host_we,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata
`endif
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ACK, ST_SUB, ST_WDATA, ST_RDATA, ST_IGNORE
    } state_t;

    // bit 1 = SCL, bit 0 = SDA; both idle high
    logic [1:0] raw, sync1, sync2, filt, filt_q;
    assign raw = {I2C_SCL, I2C_SDA};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [CW-1:0] cnt;
        // filt only follows sync2 after FILT_LEN consecutive differing samples
        always_ff @(posedge iCLK) begin
            if (!iRST_N) begin
                sync1[g]  <= 1'b1;
                sync2[g]  <= 1'b1;
                filt[g]   <= 1'b1;
                filt_q[g] <= 1'b1;
                cnt       <= '0;
            end else begin
                sync1[g]  <= raw[g];
                sync2[g]  <= sync1[g];
                filt_q[g] <= filt[g];
                if (sync2[g] == filt[g]) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILT_LEN - 1)) begin
                    filt[g] <= sync2[g];
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    logic sda, scl_rise, scl_fall, start_c, stop_c;
    assign sda      = filt[0];
    assign scl_rise =  filt[1] & ~filt_q[1];
    assign scl_fall = ~filt[1] &  filt_q[1];
    assign start_c  =  filt_q[0] & ~filt[0] & filt[1] & filt_q[1];
    assign stop_c   = ~filt_q[0] &  filt[0] & filt[1] & filt_q[1];

    state_t     state, ack_nxt;
    logic       ack_drv, sda_oe;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, ptr;
    logic [7:0] bank [256];
    logic [7:0] byte_in;
    logic       commit;

    assign byte_in = {shreg[6:0], sda};
    assign commit  = (state == ST_WDATA) && scl_rise && (bit_cnt == 4'd7) && !start_c && !stop_c;

    // Reset gates the driver directly so SDA is released in the cycle reset is applied.
    assign I2C_SDA = (sda_oe && iRST_N) ? 1'b0 : 1'bz;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state   <= ST_IDLE;
            ack_nxt <= ST_IDLE;
            ack_drv <= 1'b0;
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            shreg   <= 8'h00;
            ptr     <= 8'h00;
            wr_stb  <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            busy    <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (stop_c) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_c) begin
                // PTR is kept so a sub-address write can be followed by a read
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ST_ADDR, ST_SUB, ST_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                ack_drv <= 1'b0;
                                state   <= ST_ACK;
                                case (state)
                                    ST_ADDR: begin
                                        if (byte_in[7:1] == DEV_ADDR) begin
                                            busy    <= 1'b1;
                                            ack_nxt <= byte_in[0] ? ST_RDATA : ST_SUB;
                                        end else begin
                                            busy  <= 1'b0;
                                            state <= ST_IGNORE;
                                        end
                                    end
                                    ST_SUB: begin
                                        ptr     <= byte_in;
                                        ack_nxt <= ST_WDATA;
                                    end
                                    default: begin
                                        wr_stb  <= 1'b1;
                                        wr_addr <= ptr;
                                        wr_data <= byte_in;
                                        ptr     <= ptr + 8'd1;
                                        ack_nxt <= ST_WDATA;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ACK: begin
                        // first falling edge starts the ack, second one ends it
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                ack_drv <= 1'b1;
                                sda_oe  <= 1'b1;
                            end else begin
                                state   <= ack_nxt;
                                bit_cnt <= 4'd0;
                                if (ack_nxt == ST_RDATA) begin
                                    shreg  <= bank[ptr];
                                    sda_oe <= ~bank[ptr][7];
                                end else begin
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        // bit_cnt: 1..8 bits sent, 9 = initiator acked, reload on next fall
                        if (scl_rise) begin
                            if (bit_cnt == 4'd8) begin
                                ptr <= ptr + 8'd1;
                                if (sda) state   <= ST_IGNORE;
                                else     bit_cnt <= 4'd9;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd9) begin
                                shreg   <= bank[ptr];
                                sda_oe  <= ~bank[ptr][7];
                                bit_cnt <= 4'd0;
                            end else if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int i = 0; i < 256; i++) bank[i] <= 8'h00;
`ifdef I2C_REG_TARGET_HOST_PORT_EN
            host_rdata <= 8'h00;
`endif
        end else begin
`ifdef I2C_REG_TARGET_HOST_PORT_EN
            host_rdata <= bank[host_addr];
            if (host_we) bank[host_addr] <= host_wdata;
`endif
            // placed last so an I2C commit overrides a host write to the same address
            if (commit) bank[ptr] <= byte_in;
        end
    end

endmodule
